mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM states, the
// starvation default and the access-mode encodings understood by the data memory.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } arb_state_e;

  localparam int STARVE_MAX_DEFAULT = 4;

  localparam int MEM_MODE_W = 3;
  typedef logic [MEM_MODE_W-1:0] mem_mode_t;

  // Byte/half/word with sign- or zero-extension on loads.
  localparam mem_mode_t MODE_BYTE   = 3'b000;
  localparam mem_mode_t MODE_HALF   = 3'b001;
  localparam mem_mode_t MODE_WORD   = 3'b010;
  localparam mem_mode_t MODE_BYTE_U = 3'b100;
  localparam mem_mode_t MODE_HALF_U = 3'b101;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between the instruction-fetch and the
// load/store ports; data wins unless the fetch side has been starved too long.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_valid,
  output logic [31:0] if_rdata,

  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  mem_mode_t   dm_mode,
  output logic        dm_valid,
  output logic [31:0] dm_rdata,

  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output mem_mode_t   mem_mode,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,

  output logic        stall
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  arb_state_e       state_q,      state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             mem_req_q,    mem_req_d;
  logic             mem_we_q,     mem_we_d;
  logic [31:0]      mem_addr_q,   mem_addr_d;
  logic [31:0]      mem_wdata_q,  mem_wdata_d;
  mem_mode_t        mem_mode_q,   mem_mode_d;
  logic             if_valid_q,   if_valid_d;
  logic [31:0]      if_rdata_q,   if_rdata_d;
  logic             dm_valid_q,   dm_valid_d;
  logic [31:0]      dm_rdata_q,   dm_rdata_d;

  logic arb_point;
  logic fetch_done;
  logic data_done;
  logic grant_dm;
  logic grant_if;

  // The memory is re-arbitrated in the same cycle a transaction completes,
  // so back-to-back grants never leave an idle cycle on the bus.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_mode_d   = mem_mode_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;

    fetch_done = (state_q == FETCH) && mem_ready;
    data_done  = (state_q == DATA)  && mem_ready;
    arb_point  = (state_q == IDLE) || fetch_done || data_done;

    grant_dm = arb_point && dm_req && ((starve_cnt_q < STARVE_LIM) || !if_req);
    grant_if = arb_point && if_req && !grant_dm;

    if_valid_d = fetch_done;
    dm_valid_d = data_done;
    if (fetch_done) begin
      if_rdata_d = mem_rdata;
    end
    // Stores complete with a pulse but leave the last load result visible.
    if (data_done && !mem_we_q) begin
      dm_rdata_d = mem_rdata;
    end

    if (grant_dm) begin
      state_d     = DATA;
      mem_we_d    = dm_we;
      mem_addr_d  = dm_addr;
      mem_wdata_d = dm_wdata;
      mem_mode_d  = dm_mode;
      if (if_req && (starve_cnt_q < STARVE_LIM)) begin
        starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end
    end else if (grant_if) begin
      state_d      = FETCH;
      mem_we_d     = 1'b0;
      mem_addr_d   = if_addr;
      mem_wdata_d  = '0;
      mem_mode_d   = MODE_WORD;
      starve_cnt_d = '0;
    end else if (arb_point) begin
      state_d = IDLE;
    end

    mem_req_d = (state_d != IDLE);
  end

  // Asynchronous reset clears every flop, so an in-flight transaction is
  // dropped immediately and never reports completion.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_mode_q   <= '0;
      if_valid_q   <= 1'b0;
      if_rdata_q   <= '0;
      dm_valid_q   <= 1'b0;
      dm_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_mode_q   <= mem_mode_d;
      if_valid_q   <= if_valid_d;
      if_rdata_q   <= if_rdata_d;
      dm_valid_q   <= dm_valid_d;
      dm_rdata_q   <= dm_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_mode  = mem_mode_q;
  assign if_valid  = if_valid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_valid  = dm_valid_q;
  assign dm_rdata  = dm_rdata_q;

  assign stall = (if_req & ~if_valid_q) | (dm_req & ~dm_valid_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: grant table, directed multi-cycle
// sequences and a randomized run against a transaction-level reference model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int STARVE_MAX = 4;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  mem_mode_t   dm_mode;
  logic        dm_valid;
  logic [31:0] dm_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  mem_mode_t   mem_mode;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        stall;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_valid  (if_valid),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_mode   (dm_mode),
    .dm_valid  (dm_valid),
    .dm_rdata  (dm_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_mode  (mem_mode),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .stall     (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req    = 1'b0;
    if_addr   = '0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    dm_addr   = '0;
    dm_wdata  = '0;
    dm_mode   = MODE_WORD;
    mem_ready = 1'b0;
    mem_rdata = '0;
  endtask

  // Leaves the bench just after a rising edge with reset released, so the
  // next edge is the first one that may grant.
  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst = 1'b1;
  endtask

  // ---------------- grant table ----------------
  typedef struct {
    logic        if_req;
    logic        dm_req;
    logic        dm_we;
    mem_mode_t   dm_mode;
    logic        exp_stall;
    logic        exp_req;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    mem_mode_t   exp_mode;
  } vec_t;

  vec_t vecs[6];

  // ---------------- reference model ----------------
  localparam int OWN_NONE = 0;
  localparam int OWN_IF   = 1;
  localparam int OWN_DM   = 2;

  int          m_owner;
  int          m_starve;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  mem_mode_t   m_mode;
  logic        m_if_valid;
  logic        m_dm_valid;
  logic [31:0] m_if_rdata;
  logic [31:0] m_dm_rdata;

  task automatic model_reset();
    m_owner    = OWN_NONE;
    m_starve   = 0;
    m_we       = 1'b0;
    m_addr     = '0;
    m_wdata    = '0;
    m_mode     = '0;
    m_if_valid = 1'b0;
    m_dm_valid = 1'b0;
    m_if_rdata = '0;
    m_dm_rdata = '0;
  endtask

  // One clock of the arbiter's rules, applied to the inputs seen at the edge.
  task automatic model_step();
    bit busy;
    bit done;
    busy = (m_owner != OWN_NONE);
    done = busy && mem_ready;
    m_if_valid = done && (m_owner == OWN_IF);
    m_dm_valid = done && (m_owner == OWN_DM);
    if (m_if_valid) m_if_rdata = mem_rdata;
    if (m_dm_valid && !m_we) m_dm_rdata = mem_rdata;
    if (!busy || done) begin
      if (dm_req && (m_starve < STARVE_MAX || !if_req)) begin
        m_owner = OWN_DM;
        m_we    = dm_we;
        m_addr  = dm_addr;
        m_wdata = dm_wdata;
        m_mode  = dm_mode;
        if (if_req && m_starve < STARVE_MAX) m_starve = m_starve + 1;
      end else if (if_req) begin
        m_owner  = OWN_IF;
        m_we     = 1'b0;
        m_addr   = if_addr;
        m_wdata  = '0;
        m_mode   = MODE_WORD;
        m_starve = 0;
      end else begin
        m_owner = OWN_NONE;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    #3;

    // ---- reset state, with requests asserted during reset ----
    rst = 1'b0;
    #1;
    dm_req = 1'b1;
    if_req = 1'b1;
    mem_ready = 1'b1;
    tick();
    check("rst_mem_req",  mem_req,  0);
    check("rst_mem_we",   mem_we,   0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_if_valid", if_valid, 0);
    check("rst_dm_valid", dm_valid, 0);
    check("rst_dm_rdata", dm_rdata, 0);

    // ---- grant table from IDLE ----
    vecs[0] = '{1'b0, 1'b0, 1'b0, MODE_BYTE,   1'b0, 1'b0, 1'b0, 32'h0,  32'h0,        MODE_BYTE};
    vecs[1] = '{1'b1, 1'b0, 1'b0, MODE_HALF,   1'b1, 1'b1, 1'b0, 32'h40, 32'h0,        MODE_WORD};
    vecs[2] = '{1'b0, 1'b1, 1'b0, MODE_BYTE_U, 1'b1, 1'b1, 1'b0, 32'h80, 32'hA5A5F00D, MODE_BYTE_U};
    vecs[3] = '{1'b0, 1'b1, 1'b1, MODE_HALF,   1'b1, 1'b1, 1'b1, 32'h80, 32'hA5A5F00D, MODE_HALF};
    vecs[4] = '{1'b1, 1'b1, 1'b0, MODE_WORD,   1'b1, 1'b1, 1'b0, 32'h80, 32'hA5A5F00D, MODE_WORD};
    vecs[5] = '{1'b1, 1'b1, 1'b1, MODE_HALF_U, 1'b1, 1'b1, 1'b1, 32'h80, 32'hA5A5F00D, MODE_HALF_U};
    for (int i = 0; i < 6; i++) begin
      do_reset();
      if_req   = vecs[i].if_req;
      if_addr  = 32'h40;
      dm_req   = vecs[i].dm_req;
      dm_we    = vecs[i].dm_we;
      dm_addr  = 32'h80;
      dm_wdata = 32'hA5A5F00D;
      dm_mode  = vecs[i].dm_mode;
      #1;
      check($sformatf("vec%0d_stall", i), stall, vecs[i].exp_stall);
      check($sformatf("vec%0d_mem_req_pre", i), mem_req, 0);
      tick();
      check($sformatf("vec%0d_mem_req", i),   mem_req,   vecs[i].exp_req);
      check($sformatf("vec%0d_mem_we", i),    mem_we,    vecs[i].exp_we);
      check($sformatf("vec%0d_mem_addr", i),  mem_addr,  vecs[i].exp_addr);
      check($sformatf("vec%0d_mem_wdata", i), mem_wdata, vecs[i].exp_wdata);
      if (vecs[i].exp_req)
        check($sformatf("vec%0d_mem_mode", i), mem_mode, vecs[i].exp_mode);
    end

    // ---- lone fetch: 2-cycle latency ----
    do_reset();
    if_req  = 1'b1;
    if_addr = 32'h10;
    #1;
    check("if_only_stall_req", stall, 1);
    tick();
    check("if_only_mem_req",  mem_req,  1);
    check("if_only_mem_addr", mem_addr, 32'h10);
    check("if_only_mem_we",   mem_we,   0);
    check("if_only_mem_mode", mem_mode, MODE_WORD);
    check("if_only_valid_early", if_valid, 0);
    mem_ready = 1'b1;
    mem_rdata = 32'h0BADC0DE;
    if_req    = 1'b0;
    tick();
    check("if_only_valid",   if_valid, 1);
    check("if_only_rdata",   if_rdata, 32'h0BADC0DE);
    check("if_only_stall",   stall,    0);
    check("if_only_idle",    mem_req,  0);
    mem_ready = 1'b0;
    tick();
    check("if_only_pulse",   if_valid, 0);
    check("if_only_stall2",  stall,    0);

    // ---- simultaneous fetch and load: data first ----
    do_reset();
    if_req  = 1'b1;
    if_addr = 32'h10;
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 32'h100;
    dm_mode = MODE_WORD;
    tick();
    check("both_first_addr", mem_addr, 32'h100);
    check("both_first_we",   mem_we,   0);
    check("both_stall1",     stall,    1);
    mem_ready = 1'b1;
    mem_rdata = 32'h11110000;
    dm_req    = 1'b0;
    tick();
    check("both_dm_valid",   dm_valid, 1);
    check("both_dm_rdata",   dm_rdata, 32'h11110000);
    check("both_if_not_yet", if_valid, 0);
    check("both_fetch_addr", mem_addr, 32'h10);
    check("both_stall2",     stall,    1);
    mem_ready = 1'b0;
    tick();
    check("both_wait_if",    if_valid, 0);
    check("both_wait_dm",    dm_valid, 0);
    check("both_stall3",     stall,    1);
    mem_ready = 1'b1;
    mem_rdata = 32'h22220000;
    tick();
    check("both_if_valid",   if_valid, 1);
    check("both_if_rdata",   if_rdata, 32'h22220000);
    check("both_stall_end",  stall,    0);

    // ---- starvation bound ----
    do_reset();
    if_req    = 1'b1;
    if_addr   = 32'h10;
    dm_req    = 1'b1;
    dm_we     = 1'b0;
    dm_addr   = 32'h200;
    mem_ready = 1'b1;
    mem_rdata = 32'h33330000;
    for (int k = 1; k <= STARVE_MAX; k++) begin
      tick();
      check($sformatf("starve_data%0d", k), mem_addr, 32'h200);
    end
    tick();
    check("starve_fetch_addr", mem_addr, 32'h10);
    check("starve_fetch_we",   mem_we,   0);
    check("starve_dm_valid",   dm_valid, 1);
    tick();
    check("starve_if_valid",   if_valid, 1);
    check("starve_data_again", mem_addr, 32'h200);

    // ---- load, then back-to-back store held for 3 waits ----
    do_reset();
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 32'h24;
    dm_mode = MODE_WORD;
    tick();
    mem_ready = 1'b1;
    mem_rdata = 32'h12345678;
    dm_we     = 1'b1;
    dm_addr   = 32'h20;
    dm_wdata  = 32'hDEADBEEF;
    tick();
    check("st_load_valid", dm_valid, 1);
    check("st_load_rdata", dm_rdata, 32'h12345678);
    check("st_b2b_req",    mem_req,  1);
    mem_ready = 1'b0;
    mem_rdata = 32'h5555AAAA;
    if_req    = 1'b1;
    if_addr   = 32'hBAD0;
    for (int w = 0; w < 3; w++) begin
      check($sformatf("st_we_w%0d", w),    mem_we,    1);
      check($sformatf("st_addr_w%0d", w),  mem_addr,  32'h20);
      check($sformatf("st_wdata_w%0d", w), mem_wdata, 32'hDEADBEEF);
      check($sformatf("st_mode_w%0d", w),  mem_mode,  MODE_WORD);
      tick();
      check($sformatf("st_novalid_w%0d", w), dm_valid, 0);
    end
    mem_ready = 1'b1;
    dm_req    = 1'b0;
    tick();
    check("st_valid",     dm_valid, 1);
    check("st_rdata_keep", dm_rdata, 32'h12345678);

    // ---- reset in the middle of DATA ----
    do_reset();
    dm_req  = 1'b1;
    dm_addr = 32'h300;
    tick();
    check("mid_rst_req_before", mem_req, 1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_req_drop", mem_req,  0);
    check("mid_rst_addr",     mem_addr, 0);
    check("mid_rst_state",    32'(dut.state_q), 32'(IDLE));
    mem_ready = 1'b1;
    mem_rdata = 32'h77777777;
    tick();
    check("mid_rst_no_valid", dm_valid, 0);
    rst    = 1'b1;
    dm_req = 1'b0;
    tick();
    check("mid_rst_idle_req", mem_req,  0);
    check("mid_rst_idle_dmv", dm_valid, 0);
    check("mid_rst_idle_ifv", if_valid, 0);
    check("mid_rst_rdata",    dm_rdata, 0);

    // ---- randomized run against the reference model ----
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      if_req    = ($urandom_range(0, 9) < 6);
      if_addr   = $urandom;
      dm_req    = ($urandom_range(0, 9) < 7);
      dm_we     = $urandom_range(0, 1);
      dm_addr   = $urandom;
      dm_wdata  = $urandom;
      dm_mode   = 3'($urandom_range(0, 7));
      mem_ready = ($urandom_range(0, 9) < 5);
      mem_rdata = $urandom;
      #1;
      check("rnd_stall", stall,
            (if_req & ~m_if_valid) | (dm_req & ~m_dm_valid));
      @(posedge clk);
      model_step();
      #1;
      check("rnd_mem_req",  mem_req,  (m_owner != OWN_NONE));
      check("rnd_if_valid", if_valid, m_if_valid);
      check("rnd_dm_valid", dm_valid, m_dm_valid);
      check("rnd_if_rdata", if_rdata, m_if_rdata);
      check("rnd_dm_rdata", dm_rdata, m_dm_rdata);
      if (m_owner != OWN_NONE) begin
        check("rnd_mem_we",    mem_we,    m_we);
        check("rnd_mem_addr",  mem_addr,  m_addr);
        check("rnd_mem_wdata", mem_wdata, m_wdata);
        check("rnd_mem_mode",  mem_mode,  m_mode);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
